risc_spm_mem_loader: RTL and testbench

- Memory unit directly downstream of RISC_SPM. It consumes the processor's address, data_in and write, and returns data_out.
- Adds a byte-stream program-loader port so the bench or boot logic can fill memory before execution.
- While a load is in progress, the processor is held off through cpu_hold.
- Keeps a saturating count of processor writes for coverage and debug.

---
 rtl/risc_spm_pkg.sv | 18 +
 rtl/risc_spm_ram.sv | 25 ++
 rtl/risc_spm_mem_loader.sv | 124 ++++++++++++
 tb/tb_risc_spm_mem_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_spm_pkg.sv
// Shared widths, word/address types and loader state encoding for the RISC_SPM
// memory unit.
package risc_spm_pkg;

    localparam int WORD_W = 8;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/risc_spm_ram.sv
// Storage array for the RISC_SPM memory: one synchronous write port and one
// asynchronous read port (read-during-write returns the old word).
module risc_spm_ram #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/risc_spm_mem_loader.sv
// RISC_SPM memory with a byte-stream program loader that holds the processor
// off while a load runs, plus a saturating count of processor writes.
module risc_spm_mem_loader
    import risc_spm_pkg::*;
#(
    parameter int WORD_W = risc_spm_pkg::WORD_W,
    parameter int ADDR_W = risc_spm_pkg::ADDR_W,
    parameter int CNT_W  = risc_spm_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] data_in,
    input  logic              write,
    output logic [WORD_W-1:0] data_out,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_hold,
    output logic [CNT_W-1:0]  wr_count
);

    ld_state_e         r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_ldReady;
    logic              r_ldDone;
    logic              r_cpuHold;
    logic [CNT_W-1:0]  r_wrCount;

    logic              w_ldFire;
    logic              w_cpuFire;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WORD_W-1:0] w_wdata;

    // Loader owns the write port in LOAD; cpu_hold already blocks the processor there.
    assign w_ldFire  = (r_state == LOAD) && ld_valid;
    assign w_cpuFire = write && !r_cpuHold;
    assign w_we      = w_ldFire || w_cpuFire;
    assign w_waddr   = w_ldFire ? r_ptr   : address;
    assign w_wdata   = w_ldFire ? ld_data : data_in;

    risc_spm_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (address),
        .o_rdata (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_ldReady   <= 1'b0;
            r_ldDone    <= 1'b0;
            r_cpuHold   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ld_start) begin
                        r_cpuHold <= 1'b1;
                        if (ld_len != '0) begin
                            r_ptr       <= ld_base;
                            r_remaining <= ld_len;
                            r_ldReady   <= 1'b1;
                            r_state     <= LOAD;
                        end else begin
                            r_ldDone <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        r_ptr       <= r_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == 1) begin
                            r_ldReady <= 1'b0;
                            r_ldDone  <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_ldDone  <= 1'b0;
                    r_cpuHold <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_ldReady <= 1'b0;
                    r_ldDone  <= 1'b0;
                    r_cpuHold <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of processor writes that actually reached memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrCount <= '0;
        end else if (w_cpuFire && (r_wrCount != '1)) begin
            r_wrCount <= r_wrCount + 1'b1;
        end
    end

    assign ld_ready = r_ldReady;
    assign ld_done  = r_ldDone;
    assign cpu_hold = r_cpuHold;
    assign wr_count = r_wrCount;

endmodule

// File: tb/tb_risc_spm_mem_loader.sv
// Directed self-checking bench for risc_spm_mem_loader: processor access, loads
// with stalls and wrap-around, reset mid-load, zero-length load and saturation.
module tb_risc_spm_mem_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  address;
    logic [7:0]  data_in;
    logic        write;
    logic [7:0]  data_out;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic [8:0]  ld_len;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        cpu_hold;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    risc_spm_mem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .data_in  (data_in),
        .write    (write),
        .data_out (data_out),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .cpu_hold (cpu_hold),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkMem(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        address = addr;
        #1;
        checkOutput(tag, {24'd0, data_out}, {24'd0, exp});
    endtask

    task automatic cpuWrite(input logic [7:0] addr, input logic [7:0] data);
        address = addr;
        data_in = data;
        write   = 1'b1;
        tick();
        write   = 1'b0;
    endtask

    task automatic startLoad(input logic [7:0] base, input logic [8:0] len);
        ld_base  = base;
        ld_len   = len;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    logic [7:0] bytes2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst = 1'b1; address = '0; data_in = '0; write = 1'b0;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_ld_ready", {31'd0, ld_ready}, 32'd0);
        checkOutput("reset_ld_done", {31'd0, ld_done}, 32'd0);
        checkOutput("reset_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        checkOutput("reset_wr_count", {16'd0, wr_count}, 32'd0);

        // Processor write and read-back, then read-during-write returns old word
        cpuWrite(8'h10, 8'hA5);
        checkMem("cpu_wr_10", 8'h10, 8'hA5);
        checkOutput("wr_count_1", {16'd0, wr_count}, 32'd1);
        data_in = 8'h5A;
        write   = 1'b1;
        #1;
        checkOutput("rdw_old_word", {24'd0, data_out}, 32'hA5);
        tick();
        write = 1'b0;
        checkMem("rdw_new_word", 8'h10, 8'h5A);
        checkOutput("wr_count_2", {16'd0, wr_count}, 32'd2);
        cpuWrite(8'h80, 8'h3C);
        checkOutput("wr_count_3", {16'd0, wr_count}, 32'd3);

        // Four-byte load at base 0 while the processor tries to write 0x80
        startLoad(8'h00, 9'd4);
        address = 8'h80; data_in = 8'hFF; write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("load4_hold_%0d", i), {31'd0, cpu_hold}, 32'd1);
            checkOutput($sformatf("load4_ready_%0d", i), {31'd0, ld_ready}, 32'd1);
            checkOutput($sformatf("load4_nodone_%0d", i), {31'd0, ld_done}, 32'd0);
            ld_valid = 1'b1;
            ld_data  = bytes2[i];
            tick();
        end
        ld_valid = 1'b0;
        checkOutput("load4_done", {31'd0, ld_done}, 32'd1);
        checkOutput("load4_done_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("load4_done_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        write = 1'b0;
        checkOutput("load4_idle_done", {31'd0, ld_done}, 32'd0);
        checkOutput("load4_idle_hold", {31'd0, cpu_hold}, 32'd0);
        checkOutput("held_wr_count", {16'd0, wr_count}, 32'd3);
        checkMem("held_wr_mem80", 8'h80, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            checkMem($sformatf("load4_mem_%0d", i), 8'(i), bytes2[i]);
        end

        // Wrap-around load with ld_valid toggling every other cycle
        cpuWrite(8'h01, 8'h77);
        startLoad(8'hFE, 9'd3);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("wrap_ready_%0d", c), {31'd0, ld_ready}, 32'd1);
            checkOutput($sformatf("wrap_nodone_%0d", c), {31'd0, ld_done}, 32'd0);
            ld_valid = (c % 2 == 1);
            ld_data  = 8'hD1 + 8'(c / 2);
            tick();
        end
        ld_valid = 1'b0;
        checkOutput("wrap_done", {31'd0, ld_done}, 32'd1);
        tick();
        checkMem("wrap_mem_fe", 8'hFE, 8'hD1);
        checkMem("wrap_mem_ff", 8'hFF, 8'hD2);
        checkMem("wrap_mem_00", 8'h00, 8'hD3);
        checkMem("wrap_mem_01", 8'h01, 8'h77);

        // Reset after three bytes of an eight-byte load
        cpuWrite(8'h43, 8'h99);
        startLoad(8'h40, 9'd8);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hB1 + 8'(i);
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_hold", {31'd0, cpu_hold}, 32'd0);
        checkOutput("rst_mid_ready", {31'd0, ld_ready}, 32'd0);
        checkOutput("rst_mid_done", {31'd0, ld_done}, 32'd0);
        tick();
        checkOutput("rst_mid_nodone", {31'd0, ld_done}, 32'd0);
        checkOutput("rst_mid_count", {16'd0, wr_count}, 32'd0);
        checkMem("rst_mid_mem40", 8'h40, 8'hB1);
        checkMem("rst_mid_mem41", 8'h41, 8'hB2);
        checkMem("rst_mid_mem42", 8'h42, 8'hB3);
        checkMem("rst_mid_mem43", 8'h43, 8'h99);

        // Zero-length load goes straight to DONE
        startLoad(8'h10, 9'd0);
        checkOutput("len0_done", {31'd0, ld_done}, 32'd1);
        checkOutput("len0_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("len0_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        checkOutput("len0_idle_done", {31'd0, ld_done}, 32'd0);
        checkOutput("len0_idle_hold", {31'd0, cpu_hold}, 32'd0);
        checkMem("len0_mem10", 8'h10, 8'h5A);

        // 65536 processor writes saturate the counter
        address = 8'h20;
        write   = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            data_in = 8'(i);
            tick();
        end
        checkOutput("sat_fffe", {16'd0, wr_count}, 32'hFFFE);
        data_in = 8'hFE;
        tick();
        checkOutput("sat_ffff", {16'd0, wr_count}, 32'hFFFF);
        data_in = 8'hFF;
        tick();
        write = 1'b0;
        checkOutput("sat_hold", {16'd0, wr_count}, 32'hFFFF);
        checkMem("sat_last_data", 8'h20, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
